// File: rtl/jtsdram_pkg.sv
// Shared types and constants for the SDRAM read/write channel checker.
package jtsdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_PRE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } state_e;

    // Galois right-shift masks: tap k maps to bit k-1
    localparam logic [15:0] JTSDRAM_TAPS16 = 16'hB400;
    localparam logic [31:0] JTSDRAM_TAPS32 = 32'h8020_0003;

    localparam int JTSDRAM_TOUT_W = 8;

endpackage

// File: rtl/jtsdram_lfsr.sv
// Galois LFSR pattern generator; one step per word, reloadable to the seed.
module jtsdram_lfsr
    import jtsdram_pkg::*;
#(
    parameter int            DW   = 16,
    parameter logic [DW-1:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    output logic [DW-1:0] val_o
);

    localparam logic [DW-1:0] SEED_NZ = (SEED == '0) ? DW'(1) : SEED;
    localparam logic [DW-1:0] TAPS    = (DW == 32) ? DW'(JTSDRAM_TAPS32) : DW'(JTSDRAM_TAPS16);

    logic [DW-1:0] val_q;

    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            val_q <= SEED_NZ;
        end else if (step_i) begin
            val_q <= (val_q >> 1) ^ (val_q[0] ? TAPS : '0);
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/jtsdram_rwchk.sv
// SDRAM channel checker: writes an LFSR pattern over a window, reads it back and compares.
// Error logging (err_cnt/err_addr/err_data) is built only when JTSDRAM_ERRLOG_EN is defined.
module jtsdram_rwchk
    import jtsdram_pkg::*;
#(
    parameter int          AW   = 22,
    parameter int          DW   = 16,
    parameter int unsigned LEN  = 1024,
    parameter int unsigned BASE = 0,
    parameter int          MODE = 1,
    parameter logic [31:0] SEED = 32'hACE1,
    parameter int          TOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    output logic [AW-1:0]   addr_o,
    output logic            rd_o,
    output logic            wr_o,
    output logic [DW-1:0]   din_o,
    output logic [DW/8-1:0] din_m_o,
    input  logic            ack_i,
    input  logic            rdy_i,
    input  logic [31:0]     data_read_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            bad_o,
    output logic [7:0]      err_cnt_o,
    output logic [AW-1:0]   err_addr_o,
    output logic [DW-1:0]   err_data_o
);

    localparam int CW = AW + 1;
    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [CW-1:0] LEN_C  = CW'(LEN);
    localparam logic [JTSDRAM_TOUT_W-1:0] TOUT_LIM = JTSDRAM_TOUT_W'(TOUT - 1);

    state_e                    st_q;
    logic [AW-1:0]             addr_q;
    logic [CW-1:0]             cnt_q;
    logic [JTSDRAM_TOUT_W-1:0] tmo_q;
    logic                      rd_q, wr_q, busy_q, done_q, bad_q;
    logic [DW-1:0]             lfsr_val;
    logic start_ok, in_wait, wr_fin, rd_fin, last, miss, tmo_hit;
    logic unused_rd;

    assign start_ok = start_i && (st_q == ST_IDLE || st_q == ST_DONE);
    assign in_wait  = (st_q == ST_WR_WAIT) || (st_q == ST_RD_WAIT);
    // ack+rdy together in REQ completes the access without a WAIT cycle
    assign wr_fin   = rdy_i && (st_q == ST_WR_WAIT || (st_q == ST_WR_REQ && ack_i));
    assign rd_fin   = rdy_i && (st_q == ST_RD_WAIT || (st_q == ST_RD_REQ && ack_i));
    assign last     = (cnt_q + 1'b1) == LEN_C;
    assign miss     = rd_fin && (data_read_i[DW-1:0] != lfsr_val);
    assign tmo_hit  = in_wait && !rdy_i && (tmo_q == TOUT_LIM);
    assign unused_rd = ^data_read_i;

    jtsdram_lfsr #(.DW(DW), .SEED(SEED[DW-1:0])) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_ok || st_q == ST_RD_PRE),
        .step_i (wr_fin || rd_fin),
        .val_o  (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            addr_q <= BASE_A;
            cnt_q  <= '0;
            tmo_q  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            tmo_q <= in_wait ? tmo_q + 1'b1 : '0;
            case (st_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        addr_q <= BASE_A;
                        cnt_q  <= '0;
                        bad_q  <= 1'b0;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (MODE == 1) begin
                            st_q <= ST_WR_REQ;
                            wr_q <= 1'b1;
                        end else begin
                            st_q <= ST_RD_PRE;
                        end
                    end
                end
                ST_WR_REQ, ST_WR_WAIT: begin
                    if (wr_fin) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        st_q   <= last ? ST_RD_PRE : ST_WR_REQ;
                        wr_q   <= !last;
                    end else if (st_q == ST_WR_REQ && ack_i) begin
                        st_q <= ST_WR_WAIT;
                        wr_q <= 1'b0;
                    end else if (tmo_hit) begin
                        st_q   <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        bad_q  <= 1'b1;
                    end
                end
                ST_RD_PRE: begin
                    addr_q <= BASE_A;
                    cnt_q  <= '0;
                    st_q   <= ST_RD_REQ;
                    rd_q   <= 1'b1;
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    if (rd_fin) begin
                        if (miss) bad_q <= 1'b1;
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last) begin
                            st_q   <= ST_DONE;
                            rd_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            st_q <= ST_RD_REQ;
                            rd_q <= 1'b1;
                        end
                    end else if (st_q == ST_RD_REQ && ack_i) begin
                        st_q <= ST_RD_WAIT;
                        rd_q <= 1'b0;
                    end else if (tmo_hit) begin
                        st_q   <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        bad_q  <= 1'b1;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

`ifdef JTSDRAM_ERRLOG_EN
    logic [7:0]    err_cnt_q;
    logic [AW-1:0] err_addr_q;
    logic [DW-1:0] err_data_q;

    // bad_q still low means this is the first failure of the pass
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else if (miss) begin
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
            if (!bad_q) begin
                err_addr_q <= addr_q;
                err_data_q <= data_read_i[DW-1:0];
            end
        end else if (tmo_hit && !bad_q) begin
            err_addr_q <= addr_q;
            err_data_q <= '0;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;
    assign err_data_o = err_data_q;
`else
    assign err_cnt_o  = '0;
    assign err_addr_o = '0;
    assign err_data_o = '0;
`endif

    assign addr_o  = addr_q;
    assign rd_o    = rd_q;
    assign wr_o    = wr_q;
    assign din_o   = wr_q ? lfsr_val : '0;
    assign din_m_o = '0;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign bad_o   = bad_q;

endmodule

// File: tb/tb_jtsdram_rwchk.sv
// Scoreboard bench for jtsdram_rwchk: slow memory model on instance A, single-cycle wrap-around model on B.
module tb_jtsdram_rwchk;

`ifdef JTSDRAM_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    typedef struct {
        int          kind;  // 0 write accepted, 1 read accepted, 2 end-of-pass status
        logic [21:0] addr;
        logic [15:0] data;
        logic        bad;
        logic [7:0]  ecnt;
        logic [21:0] eaddr;
        logic [15:0] edata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a, rd_a, wr_a, ack_a, rdy_a, busy_a, done_a, bad_a;
    logic [21:0] addr_a, err_addr_a;
    logic [15:0] din_a, err_data_a;
    logic [1:0]  din_m_a;
    logic [31:0] rdata_a;
    logic [7:0]  err_cnt_a;

    logic        start_b, rd_b, wr_b, ack_b, rdy_b, busy_b, done_b, bad_b;
    logic [21:0] addr_b, err_addr_b;
    logic [15:0] din_b, err_data_b;
    logic [1:0]  din_m_b;
    logic [31:0] rdata_b;
    logic [7:0]  err_cnt_b;

    jtsdram_rwchk #(.AW(22), .DW(16), .LEN(4), .BASE(32'h100), .MODE(1), .SEED(32'hACE1), .TOUT(255)) u_a (
        .clk(clk), .rst(rst), .start_i(start_a), .addr_o(addr_a), .rd_o(rd_a), .wr_o(wr_a),
        .din_o(din_a), .din_m_o(din_m_a), .ack_i(ack_a), .rdy_i(rdy_a), .data_read_i(rdata_a),
        .busy_o(busy_a), .done_o(done_a), .bad_o(bad_a), .err_cnt_o(err_cnt_a),
        .err_addr_o(err_addr_a), .err_data_o(err_data_a)
    );

    jtsdram_rwchk #(.AW(22), .DW(16), .LEN(4), .BASE(32'h3FFFFE), .MODE(1), .SEED(32'hACE1), .TOUT(255)) u_b (
        .clk(clk), .rst(rst), .start_i(start_b), .addr_o(addr_b), .rd_o(rd_b), .wr_o(wr_b),
        .din_o(din_b), .din_m_o(din_m_b), .ack_i(ack_b), .rdy_i(rdy_b), .data_read_i(rdata_b),
        .busy_o(busy_b), .done_o(done_b), .bad_o(bad_b), .err_cnt_o(err_cnt_b),
        .err_addr_o(err_addr_b), .err_data_o(err_data_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int nrd = 0;
    int hold_at = -1;
    int flip_addr = -1;
    logic stall_ack = 1'b0;
    logic dprev_a = 1'b0;
    logic dprev_b = 1'b0;
    txn_t qa[$];
    txn_t qb[$];
    logic [15:0] mem_a [int];
    logic [15:0] mem_b [int];
    logic [15:0] pat [4] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
    logic [21:0] wrap [4] = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_rw(input int kind, input logic [21:0] base);
        txn_t t;
        for (int i = 0; i < 4; i++) begin
            t = '{kind: kind, addr: base + 22'(i), data: pat[i], bad: 1'b0, ecnt: 8'h0, eaddr: 22'h0, edata: 16'h0};
            qa.push_back(t);
        end
    endtask

    task automatic push_st(input logic bad, input logic [7:0] ec, input logic [21:0] ea, input logic [15:0] ed);
        txn_t t;
        t = '{kind: 2, addr: 22'h0, data: 16'h0, bad: bad,
              ecnt: ERRLOG ? ec : 8'h0, eaddr: ERRLOG ? ea : 22'h0, edata: ERRLOG ? ed : 16'h0};
        qa.push_back(t);
    endtask

    task automatic pulse_a(input string nm);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; #1;
        chk({nm, "_wr_t1"}, wr_a, 1);
        chk({nm, "_busy_t1"}, busy_a, 1);
        chk({nm, "_done_clr"}, done_a, 0);
        chk({nm, "_bad_clr"}, bad_a, 0);
    endtask

    task automatic wait_done_a(input string nm);
        int n = 0;
        while (!done_a && n < 3000) begin @(negedge clk); #1; n++; end
        chk({nm, "_done"}, done_a, 1);
        @(negedge clk); #1;
        chk({nm, "_q_empty"}, qa.size(), 0);
    endtask

    // slow memory: ack one cycle after the request, rdy three cycles after ack
    initial begin : mem_a_model
        int ph, dly;
        logic is_wr, held;
        logic [21:0] a;
        logic [15:0] d;
        ack_a = 1'b0; rdy_a = 1'b0; rdata_a = '0; ph = 0; dly = 0; held = 1'b0;
        is_wr = 1'b0; a = '0; d = '0;
        forever begin
            @(negedge clk);
            ack_a = 1'b0; rdy_a = 1'b0;
            if (rst) ph = 0;
            else case (ph)
                0: if (wr_a || rd_a) ph = 1;
                1: if (!stall_ack) begin
                    ack_a = 1'b1; is_wr = wr_a; a = addr_a; d = din_a; held = 1'b0;
                    if (!wr_a) begin
                        held = (nrd == hold_at);
                        if (held) ack_cyc = cyc + 1;
                        nrd++;
                    end
                    dly = 3; ph = 2;
                end
                default: begin
                    dly--;
                    if (held) begin
                        if (!busy_a) ph = 0;
                    end else if (dly == 0) begin
                        rdy_a = 1'b1;
                        if (is_wr) mem_a[int'(a)] = d;
                        else rdata_a = {16'h0, mem_a[int'(a)] ^ ((int'(a) == flip_addr) ? 16'h1 : 16'h0)};
                        ph = 0;
                    end
                end
            endcase
        end
    end

    // fast memory: ack and rdy together in the request cycle
    initial begin : mem_b_model
        ack_b = 1'b0; rdy_b = 1'b0; rdata_b = '0;
        forever begin
            @(negedge clk);
            ack_b = !rst && (wr_b || rd_b);
            rdy_b = ack_b;
            if (ack_b && wr_b) mem_b[int'(addr_b)] = din_b;
            if (ack_b && rd_b) rdata_b = {16'h0, mem_b[int'(addr_b)]};
        end
    end

    initial begin : mon_a
        txn_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && (wr_a || rd_a) && ack_a) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_req: addr %0h wr %0b, nothing expected", addr_a, wr_a);
                end else begin
                    e = qa.pop_front();
                    chk("a_kind", {31'b0, rd_a}, e.kind);
                    chk("a_addr", addr_a, e.addr);
                    if (wr_a) begin
                        chk("a_din", din_a, e.data);
                        chk("a_din_m", din_m_a, 0);
                    end
                end
            end
            if (done_a && !dprev_a) begin
                if (qa.size() == 0 || qa[0].kind != 2) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_done: bad %0b, no status expected", bad_a);
                end else begin
                    e = qa.pop_front();
                    chk("a_st_bad", bad_a, e.bad);
                    chk("a_st_busy", busy_a, 0);
                    chk("a_st_err_cnt", err_cnt_a, e.ecnt);
                    chk("a_st_err_addr", err_addr_a, e.eaddr);
                    chk("a_st_err_data", err_data_a, e.edata);
                end
            end
            dprev_a = done_a;
        end
    end

    initial begin : mon_b
        txn_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && (wr_b || rd_b) && ack_b) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_req: addr %0h, nothing expected", addr_b);
                end else begin
                    e = qb.pop_front();
                    chk("b_kind", {31'b0, rd_b}, e.kind);
                    chk("b_addr", addr_b, e.addr);
                    if (wr_b) chk("b_din", din_b, e.data);
                end
            end
            if (done_b && !dprev_b) chk("b_st_bad", bad_b, 0);
            dprev_b = done_b;
        end
    end

    initial begin : main
        int n;
        txn_t t;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd", rd_a, 0);
        chk("rst_wr", wr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_bad", bad_a, 0);
        chk("rst_addr", addr_a, 22'h100);
        chk("rst_din", din_a, 0);
        chk("rst_err_cnt", err_cnt_a, 0);
        chk("rst_err_addr", err_addr_a, 0);
        chk("rst_err_data", err_data_a, 0);
        chk("rst_addr_b", addr_b, 22'h3FFFFE);
        @(negedge clk); rst = 1'b0;

        // clean pass, with a stray start while busy
        push_rw(0, 22'h100); push_rw(1, 22'h100); push_st(1'b0, 8'h0, 22'h0, 16'h0);
        pulse_a("p1");
        repeat (6) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0; #1;
        chk("p1_busy_after_restart", busy_a, 1);
        wait_done_a("p1");
        chk("p1_bad", bad_a, 0);

        // bit 0 flipped on readback at 0x102
        flip_addr = 32'h102;
        push_rw(0, 22'h100); push_rw(1, 22'h100); push_st(1'b1, 8'h1, 22'h102, 16'h7139);
        pulse_a("p2");
        wait_done_a("p2");
        chk("p2_bad", bad_a, 1);
        flip_addr = -1;

        // second read never completes
        hold_at = nrd + 1;
        push_rw(0, 22'h100);
        for (int i = 0; i < 2; i++) begin
            t = '{kind: 1, addr: 22'h100 + 22'(i), data: 16'h0, bad: 1'b0, ecnt: 8'h0, eaddr: 22'h0, edata: 16'h0};
            qa.push_back(t);
        end
        push_st(1'b1, 8'h0, 22'h101, 16'h0);
        pulse_a("p3");
        n = 0;
        while (!bad_a && n < 3000) begin @(negedge clk); #1; n++; end
        chk("tmo_bad", bad_a, 1);
        chk("tmo_latency", cyc - ack_cyc, 255);
        chk("tmo_done", done_a, 1);
        chk("tmo_busy", busy_a, 0);
        hold_at = -1;
        @(negedge clk); #1;
        chk("p3_q_empty", qa.size(), 0);

        // reset while a write is pending
        stall_ack = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; #1;
        chk("p4_wr_t1", wr_a, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        chk("p4_rst_wr", wr_a, 0);
        chk("p4_rst_busy", busy_a, 0);
        chk("p4_rst_done", done_a, 0);
        rst = 1'b0; stall_ack = 1'b0;

        push_rw(0, 22'h100); push_rw(1, 22'h100); push_st(1'b0, 8'h0, 22'h0, 16'h0);
        pulse_a("p5");
        wait_done_a("p5");

        // address window wrapping past the top of the space
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                t = '{kind: k, addr: wrap[i], data: pat[i], bad: 1'b0, ecnt: 8'h0, eaddr: 22'h0, edata: 16'h0};
                qb.push_back(t);
            end
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; #1;
        chk("b_busy_t1", busy_b, 1);
        n = 0;
        while (!done_b && n < 3000) begin @(negedge clk); #1; n++; end
        chk("b_done", done_b, 1);
        @(negedge clk); #1;
        chk("b_q_empty", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
